// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the ECDSA signing sequencer and the modular-arithmetic unit.
// Holds the secp256k1 group order N, the low-S threshold (N-1)/2, operation codes,
// error codes and the sequencer state enum.
package ecdsa_pkg;

    localparam logic [255:0] N      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] N_HALF = (N - 256'd1) >> 1;

    // Operation codes understood by the modular-arithmetic unit
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_INV = 3'b011
    } ma_op_e;

    typedef enum logic [1:0] {
        ERR_S_ZERO  = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_UNIT    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_e;

    // DONE and FAIL are not resident states: their pulses are issued on the
    // transition back to IDLE so that done/err land with the required latency.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } state_e;

    // Valid scalar: 1 <= v < N
    function automatic logic in_scalar_range(input logic [255:0] v);
        return (v != '0) && (v < N);
    endfunction

    function automatic logic is_high_s(input logic [255:0] v);
        return v > N_HALF;
    endfunction

endpackage

// File: rtl/ecdsa_sign_sequencer_op_watchdog.sv
// Per-operation watchdog: counts cycles while enabled, saturates at TIMEOUT_CYCLES.
// Latency: o_expired rises TIMEOUT_CYCLES enabled cycles after the last clear.
// Backpressure: none; clear has priority over enable.
// Ports: clk/rst_n, i_clear (restart count), i_enable (count this cycle), o_expired.
module op_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_count;

    assign o_expired = (r_count >= W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/ecdsa_sign_sequencer.sv
// ECDSA s = k^-1 * (z + r*d) mod N sequencer driving a shared modular-arithmetic unit.
// Latency: 2 cycles to first ma_start, one bubble per step, done 2 cycles after final ma_done.
// Backpressure: holds each ma_start while ma_busy is high; req ignored unless idle.
// Ports: req/z/r/d/k in, busy/done/s/err/err_code out; ma_* is the unit start/busy/done
// interface. Optional low-S normalisation (s > (N-1)/2 -> N-s) under `ECDSA_LOW_S_EN.
module ecdsa_sign_sequencer
    import ecdsa_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [255:0] z,
    input  logic [255:0] r,
    input  logic [255:0] d,
    input  logic [255:0] k,
    output logic         busy,
    output logic         done,
    output logic [255:0] s,
    output logic         err,
    output logic [1:0]   err_code,
    output logic         ma_start,
    output logic [2:0]   ma_operation,
    output logic [255:0] ma_a,
    output logic [255:0] ma_b,
    output logic [255:0] ma_modulus,
    input  logic [255:0] ma_result,
    input  logic         ma_done,
    input  logic         ma_busy,
    input  logic         ma_error
);

    state_e       r_state;
    logic [2:0]   r_step;
    logic [255:0] r_z, r_r, r_d, r_k;
    logic [255:0] r_t, r_u, r_res;
    logic         r_busy, r_done, r_err, r_ma_start;
    logic [255:0] r_s, r_ma_a, r_ma_b;
    logic [1:0]   r_err_code;
    logic [2:0]   r_ma_op;

    ma_op_e       w_op;
    logic [255:0] w_a, w_b;
    logic         w_fail;
    err_code_e    w_fail_code;
    logic         w_expired;
    logic         w_wd_clear;

    assign busy         = r_busy;
    assign done         = r_done;
    assign s            = r_s;
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign ma_start     = r_ma_start;
    assign ma_operation = r_ma_op;
    assign ma_a         = r_ma_a;
    assign ma_b         = r_ma_b;
    assign ma_modulus   = N;

    assign w_wd_clear = (r_state == ST_ISSUE) && !ma_busy;

    op_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wd_clear),
        .i_enable (r_state == ST_WAIT),
        .o_expired(w_expired)
    );

    // Micro-program operand selection
    always_comb begin
        w_op = OP_MUL;
        w_a  = '0;
        w_b  = '0;
        case (r_step)
            3'd0: begin w_op = OP_MUL; w_a = r_r; w_b = r_d; end
            3'd1: begin w_op = OP_ADD; w_a = r_z; w_b = r_t; end
            3'd2: begin w_op = OP_INV; w_a = r_k; w_b = '0;  end
            3'd3: begin w_op = OP_MUL; w_a = r_u; w_b = r_t; end
`ifdef ECDSA_LOW_S_EN
            // 0 - s mod N == N - s
            3'd4: begin w_op = OP_SUB; w_a = '0;  w_b = r_res; end
`endif
            default: ;
        endcase
    end

    // Abort conditions; unit error outranks a same-cycle ma_done, which outranks timeout
    always_comb begin
        w_fail      = 1'b0;
        w_fail_code = ERR_S_ZERO;
        case (r_state)
            ST_CHECK: begin
                if ((r_z >= N) || !in_scalar_range(r_r) || !in_scalar_range(r_d) ||
                    !in_scalar_range(r_k)) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_RANGE;
                end
            end
            ST_WAIT: begin
                if (ma_error) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_UNIT;
                end else if (!ma_done && w_expired) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_FINISH: begin
                if (r_res == '0) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_S_ZERO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_z        <= '0;
            r_r        <= '0;
            r_d        <= '0;
            r_k        <= '0;
            r_t        <= '0;
            r_u        <= '0;
            r_res      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_s        <= '0;
            r_err_code <= '0;
            r_ma_start <= 1'b0;
            r_ma_op    <= '0;
            r_ma_a     <= '0;
            r_ma_b     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ma_start <= 1'b0;
            if (w_fail) begin
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
                r_s        <= '0;
                r_err_code <= w_fail_code;
                r_state    <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req) begin
                            r_z     <= z;
                            r_r     <= r;
                            r_d     <= d;
                            r_k     <= k;
                            r_busy  <= 1'b1;
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        r_step  <= 3'd0;
                        r_state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (!ma_busy) begin
                            r_ma_start <= 1'b1;
                            r_ma_op    <= w_op;
                            r_ma_a     <= w_a;
                            r_ma_b     <= w_b;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (ma_done) begin
                            case (r_step)
                                3'd0, 3'd1: r_t   <= ma_result;
                                3'd2:       r_u   <= ma_result;
                                default:    r_res <= ma_result;
                            endcase
                            if (r_step >= 3'd3) begin
                                r_state <= ST_FINISH;
                            end else begin
                                r_step  <= r_step + 3'd1;
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_FINISH: begin
`ifdef ECDSA_LOW_S_EN
                        if ((r_step == 3'd3) && is_high_s(r_res)) begin
                            r_step  <= 3'd4;
                            r_state <= ST_ISSUE;
                        end else
`endif
                        begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_s     <= r_res;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecdsa_sign_sequencer.sv
// Self-checking bench for ecdsa_sign_sequencer with a behavioural modular-arithmetic unit.
// Latency: n/a. Backpressure: the unit model holds ma_busy while an operation is in flight.
// Expected results come from a direct big-integer evaluation of k^-1 * (z + r*d) mod N.
module tb_ecdsa_sign_sequencer;

    localparam int TMO = 1024;
    localparam logic [255:0] NN   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] HALF = (NN - 256'd1) / 256'd2;
    localparam logic [2:0] EXP_OPS [5] = '{3'b010, 3'b000, 3'b011, 3'b010, 3'b001};

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [255:0] z, r, d, k;
    logic         busy, done, err;
    logic [255:0] s;
    logic [1:0]   err_code;
    logic         ma_start;
    logic [2:0]   ma_operation;
    logic [255:0] ma_a, ma_b, ma_modulus, ma_result;
    logic         ma_done, ma_busy, ma_error;

    int n_checks = 0;
    int n_errors = 0;

    // monitor / unit bookkeeping (written only by the unit process)
    int cyc = 0;
    int n_starts = 0, n_done = 0, n_err = 0;
    int first_start_cyc = 0, last_start_cyc = 0, done_cyc = 0, err_cyc = 0, drv_cyc = 0;
    logic [2:0] ops_q[$];

    // case bookkeeping (written only by the main process)
    int sbase = 0, dbase = 0, ebase = 0, obase = 0, acc_cyc = 0;
    int mode = 0;   // 0 normal, 1 error on INV, 2 never completes
    int lat = 3;

    ecdsa_sign_sequencer #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .z(z), .r(r), .d(d), .k(k),
        .busy(busy), .done(done), .s(s), .err(err), .err_code(err_code),
        .ma_start(ma_start), .ma_operation(ma_operation),
        .ma_a(ma_a), .ma_b(ma_b), .ma_modulus(ma_modulus),
        .ma_result(ma_result), .ma_done(ma_done), .ma_busy(ma_busy), .ma_error(ma_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- big-integer helpers ----------------
    function automatic logic [255:0] addmod(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        logic [256:0] t;
        t = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] submod(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        logic [256:0] t;
        t = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        logic [511:0] p;
        p = ({256'd0, a} * {256'd0, b}) % {256'd0, m};
        return p[255:0];
    endfunction

    // Fermat inverse: a^(m-2) mod m
    function automatic logic [255:0] invmod(input logic [255:0] a, input logic [255:0] m);
        logic [255:0] e, acc;
        e   = m - 256'd2;
        acc = 256'd1;
        for (int i = 255; i >= 0; i--) begin
            acc = mulmod(acc, acc, m);
            if (e[i]) acc = mulmod(acc, a, m);
        end
        return acc;
    endfunction

    function automatic logic [255:0] unit_op(input logic [2:0] op, input logic [255:0] a,
                                             input logic [255:0] b, input logic [255:0] m);
        if (m == '0) return '0;
        case (op)
            3'b000:  return addmod(a, b, m);
            3'b001:  return submod(a, b, m);
            3'b010:  return mulmod(a, b, m);
            3'b011:  return invmod(a, m);
            default: return '0;
        endcase
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- reference model ----------------
    task automatic ref_sign(input logic [255:0] zz, input logic [255:0] rr, input logic [255:0] dd,
                            input logic [255:0] kk, output logic e_err, output logic [255:0] e_s,
                            output logic [1:0] e_code, output int e_starts);
        logic [255:0] sv;
        e_err = 1'b0; e_s = '0; e_code = 2'b00; e_starts = 0;
        if (zz >= NN || rr == 0 || rr >= NN || dd == 0 || dd >= NN || kk == 0 || kk >= NN) begin
            e_err = 1'b1; e_code = 2'b01;
        end else begin
            sv = mulmod(invmod(kk, NN), addmod(zz, mulmod(rr, dd, NN), NN), NN);
            e_starts = 4;
            if (sv == '0) begin
                e_err = 1'b1; e_code = 2'b00;
            end else begin
`ifdef ECDSA_LOW_S_EN
                if (sv > HALF) begin
                    sv = NN - sv;
                    e_starts = 5;
                end
`endif
                e_s = sv;
            end
        end
    endtask

    // ---------------- unit model + monitor ----------------
    initial begin : unit_model
        int cnt;
        logic fail_pend;
        logic [255:0] res_pend;
        cnt = 0; fail_pend = 1'b0; res_pend = '0;
        ma_done = 1'b0; ma_error = 1'b0; ma_busy = 1'b0; ma_result = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ma_done  = 1'b0;
            ma_error = 1'b0;
            if (done) begin n_done++; done_cyc = cyc; end
            if (err)  begin n_err++;  err_cyc  = cyc; end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ma_busy = 1'b0;
                    drv_cyc = cyc;
                    if (fail_pend) ma_error = 1'b1;
                    else begin ma_done = 1'b1; ma_result = res_pend; end
                end
            end
            if (ma_start) begin
                n_starts++;
                if (n_starts == sbase + 1) first_start_cyc = cyc;
                last_start_cyc = cyc;
                ops_q.push_back(ma_operation);
                res_pend  = unit_op(ma_operation, ma_a, ma_b, ma_modulus);
                fail_pend = (mode == 1) && (ma_operation == 3'b011);
                if (mode != 2) begin
                    ma_busy = 1'b1;
                    cnt = (lat < 1) ? 1 : lat;
                end
            end
        end
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout cycles %0d", cyc);
        $fatal(1, "bench did not terminate");
    end

    // ---------------- stimulus tasks ----------------
    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_busy"},  256'(busy), 256'(0));
        check_eq({pfx, "_done"},  256'(done), 256'(0));
        check_eq({pfx, "_err"},   256'(err), 256'(0));
        check_eq({pfx, "_s"},     s, 256'(0));
        check_eq({pfx, "_code"},  256'(err_code), 256'(0));
        check_eq({pfx, "_start"}, 256'(ma_start), 256'(0));
        check_eq({pfx, "_op"},    256'(ma_operation), 256'(0));
        check_eq({pfx, "_a"},     ma_a, 256'(0));
        check_eq({pfx, "_b"},     ma_b, 256'(0));
        check_eq({pfx, "_mod"},   ma_modulus, NN);
    endtask

    task automatic accept(input logic [255:0] zz, input logic [255:0] rr,
                          input logic [255:0] dd, input logic [255:0] kk);
        @(negedge clk);
        z = zz; r = rr; d = dd; k = kk; req = 1'b1;
        sbase = n_starts; dbase = n_done; ebase = n_err; obase = ops_q.size();
        @(posedge clk);
        #2;
        acc_cyc = cyc;
        check_eq("busy_on", 256'(busy), 256'(1));
        @(negedge clk);
        req = 1'b0;
        // inputs must have been latched; scramble them
        z = rnd256(); r = rnd256(); d = rnd256(); k = rnd256();
    endtask

    task automatic finish_case(input logic e_err, input logic [255:0] e_s, input logic [1:0] e_code,
                               input int e_starts, input bit chk_first);
        int waited;
        waited = 0;
        while ((n_done == dbase) && (n_err == ebase) && (waited < 5000)) begin
            // a stray request mid-operation must be ignored
            req = (e_starts >= 4) && (waited == 6);
            @(posedge clk);
            #2;
            waited++;
        end
        req = 1'b0;
        check_eq("finished", 256'(waited < 5000), 256'(1));
        repeat (3) @(posedge clk);
        #2;
        check_eq("n_done", 256'(n_done - dbase), 256'(!e_err));
        check_eq("n_err", 256'(n_err - ebase), 256'(e_err));
        check_eq("s", s, e_s);
        check_eq("busy_off", 256'(busy), 256'(0));
        check_eq("n_starts", 256'(n_starts - sbase), 256'(e_starts));
        if (e_err) check_eq("err_code", 256'(err_code), 256'(e_code));
        if (ops_q.size() - obase == e_starts)
            for (int i = 0; i < e_starts; i++)
                check_eq("op", 256'(ops_q[obase + i]), 256'(EXP_OPS[i]));
        if (chk_first && e_starts > 0) check_eq("t_first_start", 256'(first_start_cyc), 256'(acc_cyc + 2));
        if (!e_err) check_eq("t_done", 256'(done_cyc), 256'(drv_cyc + 2));
        else if (e_code == 2'b01) check_eq("t_range", 256'(err_cyc), 256'(acc_cyc + 1));
        else if (e_code == 2'b00) check_eq("t_szero", 256'(err_cyc), 256'(drv_cyc + 2));
        else if (e_code == 2'b10) check_eq("t_unit", 256'(err_cyc), 256'(drv_cyc + 1));
        else check_eq("t_timeout", 256'(err_cyc), 256'(last_start_cyc + TMO + 1));
    endtask

    task automatic run_normal(input logic [255:0] zz, input logic [255:0] rr,
                              input logic [255:0] dd, input logic [255:0] kk, input bit chk_first);
        logic e_err; logic [255:0] e_s; logic [1:0] e_code; int e_starts;
        ref_sign(zz, rr, dd, kk, e_err, e_s, e_code, e_starts);
        accept(zz, rr, dd, kk);
        finish_case(e_err, e_s, e_code, e_starts, chk_first);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [255:0] zz, rr, dd, kk;
        int waited;
        rst_n = 1'b1; req = 1'b0; z = '0; r = '0; d = '0; k = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        mode = 0; lat = 60;
        run_normal(256'd1, 256'd1, 256'd1, 256'd1, 1'b1);
        lat = 4;
        run_normal(256'd1, 256'd1, 256'd1, 256'd2, 1'b1);
        run_normal(NN - 256'd3, 256'd1, 256'd1, 256'd1, 1'b1);
        run_normal(NN - 256'd1, 256'd1, 256'd1, 256'd1, 1'b1);
        run_normal(256'd5, 256'd7, 256'd9, 256'd0, 1'b1);
        run_normal(256'd5, NN, 256'd9, 256'd3, 1'b1);

        // unit error on the inversion step
        mode = 1; lat = 2;
        accept(256'd11, 256'd22, 256'd33, 256'd44);
        finish_case(1'b1, 256'd0, 2'b10, 3, 1'b1);

        // unit never completes
        mode = 2;
        accept(256'd11, 256'd22, 256'd33, 256'd44);
        finish_case(1'b1, 256'd0, 2'b11, 1, 1'b1);

        // reset in the middle of WAIT, then a new request while the late ma_done is pending
        mode = 0; lat = 60;
        accept(256'd3, 256'd4, 256'd5, 256'd6);
        waited = 0;
        while (n_starts == sbase && waited < 100) begin @(posedge clk); #2; waited++; end
        check_eq("rst_mid_started", 256'(n_starts - sbase), 256'(1));
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        lat = 5;
        run_normal(rnd256() % NN, rnd256() % (NN - 1) + 1, rnd256() % (NN - 1) + 1,
                   rnd256() % (NN - 1) + 1, 1'b0);

        // randomized cases
        for (int it = 0; it < 10; it++) begin
            lat = $urandom_range(1, 6);
            zz = rnd256() % NN;
            rr = rnd256() % (NN - 1) + 1;
            dd = rnd256() % (NN - 1) + 1;
            kk = rnd256() % (NN - 1) + 1;
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: kk = '0;
                    1: rr = NN;
                    2: dd = NN + 256'd5;
                    default: zz = NN;
                endcase
            end
            run_normal(zz, rr, dd, kk, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
